// File: rtl/interlock_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : interlock_pkg                                            |
// | Shared state encoding and counter widths for pipe_interlock_ctrl.  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package interlock_pkg;

  // Width of the memory-wait watchdog counter.
  localparam int c_WAIT_W = 8;
  // Width of the branch flush-window counter.
  localparam int c_FL_W   = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/interlock_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : interlock_watchdog                                       |
// | Counts consecutive data-memory busy cycles and raises a sticky     |
// | error once the count reaches MAX_WAIT.                             |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module interlock_watchdog
  import interlock_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,   // first busy cycle, seen from RUN
  input  logic i_count,   // further busy cycle while waiting
  input  logic i_clear,   // memory finished, wait is over
  output logic o_stall_err
);

  localparam logic [c_WAIT_W-1:0] c_MAX    = c_WAIT_W'(MAX_WAIT);
  // The error is raised on the edge that brings the count up to MAX_WAIT.
  localparam logic [c_WAIT_W-1:0] c_MAX_M1 = c_WAIT_W'(MAX_WAIT - 1);

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_stall_err;

  // Busy-cycle counter with saturation and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_stall_err <= 1'b0;
    end else if (i_start) begin
      r_wait_cnt <= {{(c_WAIT_W-1){1'b0}}, 1'b1};
    end else if (i_count) begin
      if (r_wait_cnt < c_MAX) begin
        r_wait_cnt <= r_wait_cnt + {{(c_WAIT_W-1){1'b0}}, 1'b1};
      end
      if (r_wait_cnt >= c_MAX_M1) begin
        r_stall_err <= 1'b1;
      end
    end else if (i_clear) begin
      r_wait_cnt <= '0;
    end
  end

  assign o_stall_err = r_stall_err;

endmodule
`default_nettype wire

// File: rtl/pipe_interlock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : pipe_interlock_ctrl                                      |
// | Pipeline interlock controller: per-stage hold/flush/bubble from    |
// | load-use hazards, data-memory waits and taken branches.            |
// | Optional statistics counters: define INTERLOCK_STATS_EN.           |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module pipe_interlock_ctrl
  import interlock_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exe_valid,
  input  logic             Reg1_EX_EXFwrd_Stall,
  input  logic             Reg2_EX_EXFwrd_Stall,
  input  logic             mem_busy,
  input  logic             br_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam logic [c_FL_W-1:0] c_FL_RELOAD   = c_FL_W'(FLUSH_CYCLES - 1);
  // A one-cycle flush window is fully covered by the RUN-state flush.
  localparam bit                c_MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_FL_W-1:0] r_fl_cnt;
  logic [c_FL_W-1:0] w_fl_cnt_nxt;
  logic              w_load_use;
  logic              w_wd_err;

  assign w_load_use = exe_valid & (Reg1_EX_EXFwrd_Stall | Reg2_EX_EXFwrd_Stall);

  // State and flush-window counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_fl_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
    end
  end

  // Next-state logic; priority is mem_busy, then br_taken, then load-use.
  always_comb begin
    w_state_nxt  = r_state;
    w_fl_cnt_nxt = r_fl_cnt;
    case (r_state)
      RUN: begin
        if (mem_busy) begin
          w_state_nxt = MEMWAIT;
        end else if (br_taken && c_MULTI_FLUSH) begin
          w_state_nxt  = FLUSH;
          w_fl_cnt_nxt = c_FL_RELOAD;
        end
      end
      MEMWAIT: begin
        if (!mem_busy) begin
          w_state_nxt = RUN;
        end
      end
      FLUSH: begin
        // A busy memory freezes the flush window in place.
        if (!mem_busy) begin
          if (br_taken) begin
            w_fl_cnt_nxt = c_FL_RELOAD;
          end else if (r_fl_cnt <= {{(c_FL_W-1){1'b0}}, 1'b1}) begin
            w_fl_cnt_nxt = '0;
            w_state_nxt  = RUN;
          end else begin
            w_fl_cnt_nxt = r_fl_cnt - {{(c_FL_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_fl_cnt_nxt = '0;
      end
    endcase
  end

  // Mealy output decode; everything is held low while reset is asserted.
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    stall_err    = rst_n & w_wd_err;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          if (mem_busy) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (w_load_use) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
          end
        end
        MEMWAIT: begin
          if (mem_busy) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end
        end
        FLUSH: begin
          // IF/ID may see hold and flush together here; the flush wins.
          ifid_flush = 1'b1;
          if (mem_busy) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end
        end
        default: begin
          pc_hold = 1'b0;
        end
      endcase
    end
  end

  interlock_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     ((r_state == RUN) & mem_busy),
    .i_count     ((r_state == MEMWAIT) & mem_busy),
    .i_clear     ((r_state == MEMWAIT) & ~mem_busy),
    .o_stall_err (w_wd_err)
  );

`ifdef INTERLOCK_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counts of stall (PC held) and flush (IF/ID flushed) cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_hold && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (ifid_flush && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_interlock_ctrl.md
Name: pipe_interlock_ctrl

Overview:
- Pipeline interlock controller that consumes the forwarding unit's hazard flags together with data-memory busy and branch-taken status.
- Drives per-stage hold, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Sequences multi-cycle stalls (data-memory wait, branch flush window) and flags a stuck memory with a watchdog.
- Sits beside the hazard/forwarding unit at the top of the 5-stage pipeline.

Parameters:
- FLUSH_CYCLES, 1: number of cycles IF/ID is flushed after a taken branch; legal range 1..15.
- MAX_WAIT, 64: number of consecutive memory-busy cycles after which stall_err is raised; legal range 2..255.
- CNT_W, 16: width of the optional statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- exe_valid  in  1  EX stage holds a real instruction, not a bubble.
- Reg1_EX_EXFwrd_Stall  in  1  load in MEM writes the register that EX reads on port 1.
- Reg2_EX_EXFwrd_Stall  in  1  load in MEM writes the register that EX reads on port 2.
- mem_busy  in  1  data memory has not completed the MEM-stage access this cycle.
- br_taken  in  1  EX resolved a taken branch or jump this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID register keeps its contents.
- idex_hold  out  1  ID/EX register keeps its contents.
- exmem_hold  out  1  EX/MEM register keeps its contents.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a NOP.
- exmem_bubble  out  1  EX/MEM loads a NOP while the stages upstream of it hold.
- stall_err  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  statistics: number of stall cycles.
- flush_cycles  out  CNT_W  statistics: number of flush cycles.

Behaviour:
- Reset: already decided — one clock, clk; synchronous active-low reset, rst_n. While rst_n=0, on each rising edge the state goes to RUN, all counters clear and stall_err clears. While rst_n=0 every output is forced to 0.
- Derived signal: load_use = exe_valid & (Reg1_EX_EXFwrd_Stall | Reg2_EX_EXFwrd_Stall).
- Output timing: outputs are combinational (Mealy) from the current state and inputs, so zero-latency. Internal state changes on the next edge.
- States: RUN, MEMWAIT, FLUSH.
- Priority within a cycle: mem_busy > br_taken > load_use.
- RUN, mem_busy=1:
  - pc_hold = ifid_hold = idex_hold = exmem_hold = 1.
  - wait_cnt ← 1; next state MEMWAIT.
  - br_taken and load_use are ignored; EX re-presents them after the wait.
- RUN, br_taken=1:
  - ifid_flush = idex_flush = 1.
  - If FLUSH_CYCLES > 1: fl_cnt ← FLUSH_CYCLES−1 and next state FLUSH; otherwise stay in RUN.
  - A load_use in the same cycle is dropped, because the consumer is squashed.
- RUN, load_use=1:
  - pc_hold = ifid_hold = idex_hold = 1 and exmem_bubble = 1, for one cycle.
  - Stay in RUN. The load then reaches WB, the flags fall and WB forwarding resolves the dependency.
- MEMWAIT, mem_busy=1:
  - All four holds asserted.
  - wait_cnt increments, saturating at MAX_WAIT.
  - When wait_cnt reaches MAX_WAIT, stall_err ← 1; it stays set until reset.
- MEMWAIT, mem_busy=0:
  - All outputs 0 this cycle; next state RUN, wait_cnt ← 0.
  - br_taken and load_use are re-evaluated only from the following cycle.
- FLUSH:
  - ifid_flush = 1.
  - If mem_busy=1: all four holds are also asserted and fl_cnt is frozen.
  - Otherwise fl_cnt decrements; when fl_cnt reaches 0 the next state is RUN.
  - A new br_taken while in FLUSH reloads fl_cnt ← FLUSH_CYCLES−1.
- Hold/flush conflict: no stage may assert hold and flush in the same cycle, except IF/ID during FLUSH with mem_busy, where flush wins.
- Reset mid-stall: any state returns to RUN on the next edge with all outputs 0.

Optional Feature:
- Macro: INTERLOCK_STATS_EN.
- Defined:
  - stall_cycles increments on every cycle in which pc_hold=1.
  - flush_cycles increments on every cycle in which ifid_flush=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package interlock_pkg:
  - state enum: RUN=2'd0, MEMWAIT=2'd1, FLUSH=2'd2.
  - Widths of wait_cnt (8) and fl_cnt (4).
- Sub-module: interlock_watchdog, containing wait_cnt, the saturation logic and sticky stall_err. The FSM, output decode and optional counters stay in the top module.

Test Plan:
- Load-use: exe_valid=1, Reg2_EX_EXFwrd_Stall=1 for 1 cycle → pc_hold, ifid_hold, idex_hold and exmem_bubble high for exactly 1 cycle; state stays RUN.
- Memory wait: mem_busy high for 5 cycles → all four holds high for 5 cycles and low on the 6th; stall_cycles=5 with INTERLOCK_STATS_EN.
- Branch flush: FLUSH_CYCLES=3, br_taken pulse → ifid_flush high for 3 cycles, idex_flush high on the first cycle only.
- Priority: mem_busy, br_taken and load_use all high together → only holds asserted, no flush; the branch is honoured once mem_busy drops and br_taken is re-asserted.
- Watchdog: MAX_WAIT=4, mem_busy held high 10 cycles → stall_err rises after the 4th busy cycle and stays high after mem_busy drops, until rst_n=0.
- Reset mid-flush: rst_n=0 during FLUSH with fl_cnt=2 → outputs 0 immediately; state RUN and counters 0 after the edge.
